// File: rtl/pwm_multi_shadow.sv
// rtl/pwm_multi_shadow.sv - N-channel PWM with shared period counter and boundary-synchronised shadow settings
// Edge or center aligned; staged settings move to the active set only at a period boundary or while disabled.
module pwm_multi_shadow #(
  parameter int R = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           load,
  input  logic [R-1:0]   period,
  input  logic [N*R-1:0] duty,
  input  logic           center,
  input  logic [N-1:0]   polarity,
  output logic [N-1:0]   pwm_out,
  output logic           cycle_start,
  output logic           pending,
  output logic           update_ack
);

  localparam logic [R-1:0] CNT_ZERO = '0;
  localparam logic [R-1:0] CNT_ONE  = R'(1);

  logic [R-1:0]   cnt_q, cnt_d;
  logic           dir_q, dir_d;  // 1 = counting down (center mode only)

  logic [R-1:0]   pend_period_q, pend_period_d;
  logic [N*R-1:0] pend_duty_q, pend_duty_d;
  logic           pend_center_q, pend_center_d;
  logic [N-1:0]   pend_pol_q, pend_pol_d;
  logic           pend_v_q, pend_v_d;

  logic [R-1:0]   act_period_q, act_period_d;
  logic [N*R-1:0] act_duty_q, act_duty_d;
  logic           act_center_q, act_center_d;
  logic [N-1:0]   act_pol_q, act_pol_d;

  logic [N-1:0]   pwm_q, pwm_d;
  logic           cs_q, cs_d;
  logic           ack_q, ack_d;

  logic           boundary;
  logic           xfer;

  always_comb begin
    boundary      = 1'b0;
    xfer          = 1'b0;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_center_d = pend_center_q;
    pend_pol_d    = pend_pol_q;
    pend_v_d      = pend_v_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    act_center_d  = act_center_q;
    act_pol_d     = act_pol_q;
    pwm_d         = '0;
    cs_d          = 1'b0;
    ack_d         = 1'b0;

    // Center mode with P==1 never turns around, so its boundary is the top of the up-ramp.
    if (act_period_q == CNT_ZERO) begin
      boundary = 1'b1;
    end else if (!act_center_q) begin
      boundary = (cnt_q == act_period_q);
    end else begin
      boundary = (cnt_q == CNT_ONE) && (dir_q || (act_period_q == CNT_ONE));
    end

    xfer = (boundary || !en) && pend_v_q;

    if (!en || boundary) begin
      cnt_d = CNT_ZERO;
      dir_d = 1'b0;
    end else if (!act_center_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!dir_q) begin
      if (cnt_q == act_period_q) begin
        dir_d = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (xfer) begin
      act_period_d = pend_period_q;
      act_duty_d   = pend_duty_q;
      act_center_d = pend_center_q;
      act_pol_d    = pend_pol_q;
    end

    // A load on a transfer cycle stays staged; the old staged set is what moves.
    if (load) begin
      pend_period_d = period;
      pend_duty_d   = duty;
      pend_center_d = center;
      pend_pol_d    = polarity;
      pend_v_d      = 1'b1;
    end else if (xfer) begin
      pend_v_d = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      pwm_d[i] = (en && (cnt_q < act_duty_q[i*R +: R])) ^ act_pol_q[i];
    end
    cs_d  = en && (cnt_q == CNT_ZERO);
    ack_d = xfer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_center_q <= 1'b0;
      pend_pol_q    <= '0;
      pend_v_q      <= 1'b0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      act_center_q  <= 1'b0;
      act_pol_q     <= '0;
      pwm_q         <= '0;
      cs_q          <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_center_q <= pend_center_d;
      pend_pol_q    <= pend_pol_d;
      pend_v_q      <= pend_v_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      act_center_q  <= act_center_d;
      act_pol_q     <= act_pol_d;
      pwm_q         <= pwm_d;
      cs_q          <= cs_d;
      ack_q         <= ack_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign cycle_start = cs_q;
  assign pending     = pend_v_q;
  assign update_ack  = ack_q;

endmodule

// File: tb/tb_pwm_multi_shadow.sv
// tb/tb_pwm_multi_shadow.sv - directed and randomized checks of pwm_multi_shadow against a period-phase model
module tb_pwm_multi_shadow;

  localparam int R = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           load;
  logic [R-1:0]   period;
  logic [N*R-1:0] duty;
  logic           center;
  logic [N-1:0]   polarity;
  logic [N-1:0]   pwm_out;
  logic           cycle_start;
  logic           pending;
  logic           update_ack;

  int checks = 0;
  int errors = 0;

  // Model: active/staged settings plus position within the current period.
  int       m_P, m_d[N], m_phase;
  bit       m_c;
  bit [N-1:0] m_pol;
  int       p_P, p_d[N];
  bit       p_c, p_v;
  bit [N-1:0] p_pol;

  int hi[N];
  int cs_n, ack_n;

  pwm_multi_shadow #(.R(R), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .period     (period),
    .duty       (duty),
    .center     (center),
    .polarity   (polarity),
    .pwm_out    (pwm_out),
    .cycle_start(cycle_start),
    .pending    (pending),
    .update_ack (update_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_P = 0; m_c = 0; m_pol = '0; m_phase = 0;
    p_P = 0; p_c = 0; p_pol = '0; p_v = 0;
    for (int i = 0; i < N; i++) begin m_d[i] = 0; p_d[i] = 0; end
  endtask

  task automatic tick();
    int len, val;
    bit bnd, eack, ecs;
    bit [N-1:0] ep;
    len = m_c ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
    val = (m_c && m_phase > m_P) ? 2 * m_P - m_phase : m_phase;
    for (int i = 0; i < N; i++) ep[i] = (en && (val < m_d[i])) ^ m_pol[i];
    ecs  = en && (val == 0);
    bnd  = !en || (m_phase == len - 1);
    eack = bnd && p_v;
    m_phase = bnd ? 0 : m_phase + 1;
    if (eack) begin
      m_P = p_P; m_c = p_c; m_pol = p_pol;
      for (int i = 0; i < N; i++) m_d[i] = p_d[i];
    end
    if (load) begin
      p_P = int'(period); p_c = center; p_pol = polarity; p_v = 1;
      for (int i = 0; i < N; i++) p_d[i] = int'(duty[i*R +: R]);
    end else if (eack) begin
      p_v = 0;
    end
    @(posedge clk);
    #1;
    chk("pwm_out", pwm_out, ep);
    chk("cycle_start", cycle_start, ecs);
    chk("update_ack", update_ack, eack);
    chk("pending", pending, p_v);
    for (int i = 0; i < N; i++) hi[i] += int'(pwm_out[i]);
    cs_n  += int'(cycle_start);
    ack_n += int'(update_ack);
  endtask

  task automatic window(input int n);
    for (int i = 0; i < N; i++) hi[i] = 0;
    cs_n = 0;
    ack_n = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic prog(input int p, input logic [N*R-1:0] dv, input bit c, input logic [N-1:0] pol);
    en = 0; load = 1; period = R'(p); duty = dv; center = c; polarity = pol;
    tick();
    load = 0;
    tick();
    en = 1;
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; period = '0; duty = '0; center = 0; polarity = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pwm", pwm_out, 4'b0000);
    chk("reset_cs", cycle_start, 1'b0);
    chk("reset_pend", pending, 1'b0);
    chk("reset_ack", update_ack, 1'b0);
    rst_n = 1;

    // Edge mode, P=9
    prog(9, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 4'b0000);
    window(10);
    chk("edge_d3_hi", hi[0], 3);
    chk("edge_d3_cs", cs_n, 1);
    prog(9, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 4'b0000);
    window(10);
    chk("edge_d0_hi", hi[0], 0);
    prog(9, {8'd0, 8'd0, 8'd0, 8'd10}, 0, 4'b0000);
    window(10);
    chk("edge_d10_hi", hi[0], 10);
    prog(9, {8'd0, 8'd0, 8'd0, 8'd255}, 0, 4'b0000);
    window(10);
    chk("edge_d255_hi", hi[0], 10);

    // Center mode, P=4
    prog(4, {8'd0, 8'd0, 8'd0, 8'd2}, 1, 4'b0000);
    window(8);
    chk("ctr_d2_hi", hi[0], 3);
    chk("ctr_d2_cs", cs_n, 1);
    prog(4, {8'd0, 8'd0, 8'd0, 8'd5}, 1, 4'b0000);
    window(8);
    chk("ctr_d5_hi", hi[0], 8);

    // Shadow update mid-period
    prog(9, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 4'b0000);
    window(3);
    load = 1; duty = {8'd0, 8'd0, 8'd0, 8'd7};
    tick();
    load = 0;
    chk("shadow_pend", pending, 1'b1);
    window(12);
    chk("shadow_ack_once", ack_n, 1);
    window(10);
    chk("shadow_new_hi", hi[0], 7);
    chk("shadow_pend_clr", pending, 1'b0);

    // Load coincident with a boundary
    for (int k = 0; k < 20 && m_phase != 1; k++) tick();
    load = 1; duty = {8'd0, 8'd0, 8'd0, 8'd2};
    tick();
    load = 0;
    for (int k = 0; k < 20 && m_phase != 9; k++) tick();
    load = 1; duty = {8'd0, 8'd0, 8'd0, 8'd5};
    tick();
    load = 0;
    chk("coinc_ack", update_ack, 1'b1);
    chk("coinc_pend", pending, 1'b1);
    window(10);
    chk("coinc_hi_old", hi[0], 2);
    chk("coinc_ack_next", ack_n, 1);
    chk("coinc_pend_clr", pending, 1'b0);
    window(10);
    chk("coinc_hi_new", hi[0], 5);

    // Polarity and enable
    prog(9, {8'd3, 8'd3, 8'd3, 8'd3}, 0, 4'b0101);
    en = 0;
    tick();
    chk("pol_idle", pwm_out, 4'b0101);
    en = 1;
    window(10);
    chk("pol_ch0_hi", hi[0], 7);
    chk("pol_ch1_hi", hi[1], 3);
    chk("pol_cs", cs_n, 1);
    window(20);
    chk("pol_cs_rate", cs_n, 2);

    // Asynchronous reset mid-period with a pending update
    load = 1; duty = {8'd9, 8'd9, 8'd9, 8'd9};
    tick();
    load = 0;
    #1 rst_n = 0;
    #1;
    chk("areset_pwm", pwm_out, 4'b0000);
    chk("areset_cs", cycle_start, 1'b0);
    chk("areset_pend", pending, 1'b0);
    model_reset();
    #1 rst_n = 1;
    en = 0;
    tick();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      en = ($urandom % 16) != 0;
      load = ($urandom % 8) == 0;
      if (load) begin
        period = R'($urandom_range(0, 12));
        center = $urandom % 2;
        polarity = N'($urandom);
        for (int i = 0; i < N; i++)
          duty[i*R +: R] = (($urandom % 6) == 0) ? 8'd255 : R'($urandom_range(0, 14));
      end
      tick();
    end
    load = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
